bus_nxm: RTL and testbench
==========================

# bus_nxm

Parametrised shared bus connecting NUM_M masters to NUM_S slaves through one registered round-robin arbiter, address decoder and read-data return path. It is the next generation of the fixed 2-master/2-slave bus. It adds per-master fairness, an optional hold-limit preemption timer and a decode-error flag. All slaves share one write/address/data channel, and each master sees the same m_din return bus.

## Interface
- NUM_M, 2: number of masters, 2..8
- NUM_S, 2: number of slaves, 2..8
- AW, 8: address width
- DW, 32: data width
- REGION_BITS, 5: log2 of each slave's address window; slave index = address >> REGION_BITS
- MAX_HOLD, 0: maximum consecutive granted cycles before forced rotation when another master waits; 0 = unlimited
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m_req  in  NUM_M  per-master bus request
- m_wr  in  NUM_M  per-master write (1) / read (0)
- m_address  in  NUM_M*AW  packed addresses, master i at [i*AW +: AW]
- m_dout  in  NUM_M*DW  packed master write data
- s_dout  in  NUM_S*DW  packed slave read data
- m_grant  out  NUM_M  one-hot (or zero) registered grant
- m_din  out  DW  registered read data to all masters
- dec_err  out  1  registered decode error, aligned with m_din
- s_sel  out  NUM_S  one-hot slave select
- s_wr  out  1  write strobe to slaves
- s_address  out  AW  shared slave address
- s_din  out  DW  shared slave write data

## Operation
- Registers: owner (one-hot grant), last (index of the most recent owner), hold counter, rd_idx/rd_valid (registered slave index), m_din, dec_err.
- States: IDLE (m_grant = 0) and OWNED (exactly one m_grant bit = 1).
- IDLE: at each edge, if any m_req is set, grant the first requester searching from last+1 modulo NUM_M → OWNED. Otherwise stay in IDLE.
- OWNED, owner m_req = 1: keep the grant unless MAX_HOLD ≠ 0, hold counter = MAX_HOLD-1, and another master requests. In that case, rotate to the next requester after the owner.
- OWNED, owner m_req = 0: at the same edge, grant the next requester after the owner (no idle cycle). If there is none → IDLE.
- The hold counter increments each cycle the same owner keeps the grant. It resets to 0 on any owner change or on IDLE. It saturates at MAX_HOLD-1.
- last updates to the new owner index whenever a grant is issued.
- Slave-side outputs are combinational from the owner's inputs:
  - s_wr = owner m_wr
  - s_address = owner address
  - s_din = owner m_dout
  - s_sel = one-hot(address >> REGION_BITS) when that index < NUM_S
- With no owner, s_sel, s_wr, s_address and s_din are all 0.
- Decode miss (index ≥ NUM_S): s_sel = 0, s_wr is forced to 0, no slave is accessed.
- Read return:
  - At each edge, rd_valid = owner present & !s_wr & hit, and rd_idx = decoded index.
  - m_din = s_dout[rd_idx] when rd_valid is set, else 0.
  - dec_err = owner present & decode miss, registered.
- Width rules: the index comparison uses AW-REGION_BITS bits. Packed slices are selected by index; no arithmetic wraps beyond NUM_M/NUM_S.

## Timing
- Reset (asynchronous) values:
  - m_grant = 0, m_din = 0, dec_err = 0
  - s_sel = 0, s_wr = 0, s_address = 0, s_din = 0
  - last = NUM_M-1, so master 0 wins first; hold counter = 0; rd_valid = 0
- Grant latency: m_req high before edge n → m_grant high after edge n. Slave signals are valid in the same cycle as m_grant.
- Read latency: address/sel in cycle n → m_din and dec_err valid in cycle n+1 (one registered stage). The slave's s_dout must be valid during cycle n.
- Writes complete in the cycle s_sel & s_wr is high; there is no wait state.
- Simultaneous requests go to round-robin order. Owner release and a new request in the same cycle hand over directly at the next edge.
- A master must hold m_req, address and data stable until it observes m_grant. Dropping m_req before the grant is a legal cancel.
- Reset mid-transfer: all state clears immediately. Any in-flight read is discarded, and m_din = 0 until a new read completes.

## Test plan
- Reset, then m0 requests write to 0x00 with data 0xFFFF_FFFF → m_grant = 01 one edge later; s_sel = 01, s_wr = 1, s_din = 0xFFFF_FFFF.
- m0 reads 0x20 while s1_dout = 0xDEAD_DEAD → s_sel = 10; next cycle m_din = 0xDEAD_DEAD and dec_err = 0.
- m0 and m1 request simultaneously right after reset → m0 is granted. m0 drops req → m1 is granted at the next edge with no idle cycle. Both request again after m1 releases → m0 wins (round robin).
- MAX_HOLD = 4 and both masters hold req → grant alternates every 4 cycles: m0 ×4, m1 ×4, m0 ×4, and so on.
- m0 reads 0x40 with NUM_S = 2 → s_sel = 0, s_wr = 0; next cycle dec_err = 1, m_din = 0.
- NUM_M = 4, NUM_S = 4, all masters requesting, owner releases each cycle → grant order 0, 1, 2, 3, 0. Assert reset mid-sequence → m_grant = 0 immediately, and master 0 wins first after release.

Source files
------------

// File: rtl/bus_nxm.sv
// Shared N-master / M-slave bus with a registered round-robin arbiter,
// optional hold-limit preemption, address decode and a registered read return.
module bus_nxm #(
   parameter int unsigned NUM_M       = 2,
   parameter int unsigned NUM_S       = 2,
   parameter int unsigned AW          = 8,
   parameter int unsigned DW          = 32,
   parameter int unsigned REGION_BITS = 5,
   parameter int unsigned MAX_HOLD    = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_M-1:0]    m_req,
   input  logic [NUM_M-1:0]    m_wr,
   input  logic [NUM_M*AW-1:0] m_address,
   input  logic [NUM_M*DW-1:0] m_dout,
   input  logic [NUM_S*DW-1:0] s_dout,
   output logic [NUM_M-1:0]    m_grant,
   output logic [DW-1:0]       m_din,
   output logic                dec_err,
   output logic [NUM_S-1:0]    s_sel,
   output logic                s_wr,
   output logic [AW-1:0]       s_address,
   output logic [DW-1:0]       s_din
);

   localparam int unsigned MIW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int unsigned IW  = AW - REGION_BITS;
   localparam int unsigned HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_TOP = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

   typedef enum logic {IDLE, OWNED} state_t;

   state_t           state_q, state_d;
   logic [MIW-1:0]   last_q, last_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [NUM_M-1:0] grant_d;

   logic             owned;
   logic             own_wr;
   logic             own_req;
   logic [AW-1:0]    own_addr;
   logic [DW-1:0]    own_data;
   logic [IW-1:0]    idx;
   logic             hit;
   logic             rd_hit;
   logic [DW-1:0]    rd_data;
   logic [NUM_M-1:0] cand;
   logic             found;
   logic [MIW-1:0]   pick;

   assign owned = (state_q == OWNED);

   // Select the current owner's request, command, address and data.
   always_comb begin
      own_wr   = 1'b0;
      own_req  = 1'b0;
      own_addr = '0;
      own_data = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (owned && last_q == MIW'(i)) begin
            own_wr   = m_wr[i];
            own_req  = m_req[i];
            own_addr = m_address[i*AW +: AW];
            own_data = m_dout[i*DW +: DW];
         end
      end
   end

   // Address decode and slave-side drive; a miss selects nothing and blocks writes.
   always_comb begin
      idx     = own_addr[AW-1:REGION_BITS];
      hit     = owned && (32'(idx) < NUM_S);
      s_sel   = '0;
      rd_data = '0;
      for (int j = 0; j < NUM_S; j++) begin
         if (32'(idx) == 32'(j)) begin
            s_sel[j] = hit;
            rd_data  = s_dout[j*DW +: DW];
         end
      end
      s_wr      = hit && own_wr;
      s_address = own_addr;
      s_din     = own_data;
      rd_hit    = hit && !own_wr;
   end

   // Round-robin search for the first other requester after the last owner.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NUM_M; i++) begin
         cand[i] = m_req[i] && !(owned && last_q == MIW'(i));
      end
      for (int k = 1; k <= NUM_M; k++) begin
         for (int i = 0; i < NUM_M; i++) begin
            if (!found && cand[i] && ((32'(last_q) + 32'(k)) % NUM_M) == 32'(i)) begin
               found = 1'b1;
               pick  = MIW'(i);
            end
         end
      end
   end

   // Arbiter next state: grant, keep, hold-limit rotate, hand over or go idle.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            hold_d = '0;
            if (found) begin
               state_d = OWNED;
               last_d  = pick;
            end
         end
         OWNED: begin
            if (own_req) begin
               if (MAX_HOLD != 0 && hold_q == HOLD_TOP && found) begin
                  last_d = pick;
                  hold_d = '0;
               end else if (hold_q != HOLD_TOP) begin
                  hold_d = hold_q + 1'b1;
               end
            end else if (found) begin
               last_d = pick;
               hold_d = '0;
            end else begin
               state_d = IDLE;
               hold_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      for (int i = 0; i < NUM_M; i++) begin
         grant_d[i] = (state_d == OWNED) && (last_d == MIW'(i));
      end
   end

   // Arbiter state, grant and read-return registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= MIW'(NUM_M - 1);
         hold_q  <= '0;
         m_grant <= '0;
         m_din   <= '0;
         dec_err <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         m_grant <= grant_d;
         m_din   <= rd_hit ? rd_data : '0;
         dec_err <= owned && !hit;
      end
   end

endmodule

// File: tb/tb_bus_nxm.sv
// Randomized scoreboard bench for bus_nxm against a cycle-level arbitration model.
module tb_bus_nxm;

   localparam int NM = 4;
   localparam int NS = 3;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int RB = 5;
   localparam int MH = 3;

   logic             clk;
   logic             reset;
   logic [NM-1:0]    req;
   logic [NM-1:0]    wr;
   logic [NM*AW-1:0] m_address_v;
   logic [NM*DW-1:0] m_dout_v;
   logic [NS*DW-1:0] s_dout_v;
   logic [NM-1:0]    m_grant;
   logic [DW-1:0]    m_din;
   logic             dec_err;
   logic [NS-1:0]    s_sel;
   logic             s_wr;
   logic [AW-1:0]    s_address;
   logic [DW-1:0]    s_din;

   logic [AW-1:0] a [NM];
   logic [DW-1:0] d [NM];

   typedef struct {
      logic [NM-1:0] grant;
      logic [DW-1:0] din;
      logic          err;
      logic [NS-1:0] sel;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // Reference model state
   int            own;
   int            last;
   int            run;
   logic [DW-1:0] exp_din;
   logic          exp_err;

   bus_nxm #(
      .NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .REGION_BITS(RB), .MAX_HOLD(MH)
   ) dut (
      .clk(clk), .reset(reset),
      .m_req(req), .m_wr(wr), .m_address(m_address_v), .m_dout(m_dout_v),
      .s_dout(s_dout_v),
      .m_grant(m_grant), .m_din(m_din), .dec_err(dec_err),
      .s_sel(s_sel), .s_wr(s_wr), .s_address(s_address), .s_din(s_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NM; i++) begin
         m_address_v[i*AW +: AW] = a[i];
         m_dout_v[i*DW +: DW]    = d[i];
      end
   endtask

   task automatic model_reset();
      own     = -1;
      last    = NM - 1;
      run     = 0;
      exp_din = '0;
      exp_err = 1'b0;
   endtask

   // First requesting master after 'from' in circular order, skipping 'excl'.
   function automatic int next_req(int from, int excl);
      for (int k = 1; k <= NM; k++) begin
         int j;
         j = (from + k) % NM;
         if (req[j] && j != excl) return j;
      end
      return -1;
   endfunction

   // Push this cycle's expected outputs, then advance the model across the edge.
   task automatic model_step(input bit in_reset);
      exp_t e;
      int   idx;
      bit   hit;
      int   nxt;
      int   alt;
      if (in_reset) model_reset();
      e.grant = '0;
      e.din   = exp_din;
      e.err   = exp_err;
      e.sel   = '0;
      e.wr    = 1'b0;
      e.addr  = '0;
      e.data  = '0;
      idx     = 0;
      hit     = 1'b0;
      if (own >= 0) begin
         e.grant[own] = 1'b1;
         idx  = int'(a[own]) >> RB;
         hit  = (idx < NS);
         if (hit) e.sel[idx] = 1'b1;
         e.wr   = hit && wr[own];
         e.addr = a[own];
         e.data = d[own];
      end
      q.push_back(e);
      if (in_reset) return;
      exp_din = (own >= 0 && hit && !wr[own]) ? s_dout_v[idx*DW +: DW] : '0;
      exp_err = (own >= 0) && !hit;
      if (own < 0) begin
         nxt = next_req(last, -1);
      end else if (req[own]) begin
         alt = next_req(own, own);
         nxt = (MH != 0 && run >= MH && alt >= 0) ? alt : own;
      end else begin
         nxt = next_req(own, own);
      end
      if (own >= 0 && nxt == own) run++;
      else run = (nxt >= 0) ? 1 : 0;
      own = nxt;
      if (nxt >= 0) last = nxt;
   endtask

   task automatic new_txn(input int i);
      wr[i] = 1'($urandom);
      a[i]  = {3'($urandom_range(0, 3)), 5'($urandom)};
      d[i]  = $urandom;
   endtask

   // Masters: owners issue new commands or release; waiters hold stable or cancel.
   task automatic random_inputs();
      for (int i = 0; i < NM; i++) begin
         if (own == i) begin
            if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
            else new_txn(i);
         end else if (req[i]) begin
            if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            new_txn(i);
         end
      end
      s_dout_v = {$urandom, $urandom, $urandom};
   endtask

   // Monitor: compare every presented output cycle against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("m_grant",   64'(m_grant),   64'(e.grant));
            chk("m_din",     64'(m_din),     64'(e.din));
            chk("dec_err",   64'(dec_err),   64'(e.err));
            chk("s_sel",     64'(s_sel),     64'(e.sel));
            chk("s_wr",      64'(s_wr),      64'(e.wr));
            chk("s_address", 64'(s_address), 64'(e.addr));
            chk("s_din",     64'(s_din),     64'(e.data));
         end
      end
   end

   // Stimulus: reset, directed write/read/miss sequence, then random traffic.
   initial begin
      reset    = 1'b1;
      req      = '0;
      wr       = '0;
      s_dout_v = '0;
      for (int i = 0; i < NM; i++) begin
         a[i] = '0;
         d[i] = '0;
      end
      model_reset();
      drive();
      repeat (2) begin
         @(negedge clk);
         drive();
         model_step(1'b1);
      end
      @(negedge clk);
      reset = 1'b0;
      req   = 4'b0001;
      wr[0] = 1'b1;
      a[0]  = 8'h00;
      d[0]  = 32'hFFFF_FFFF;
      drive();
      model_step(1'b0);
      @(negedge clk);
      drive();
      model_step(1'b0);
      @(negedge clk);
      wr[0] = 1'b0;
      a[0]  = 8'h20;
      s_dout_v[DW +: DW] = 32'hDEAD_DEAD;
      drive();
      model_step(1'b0);
      @(negedge clk);
      wr[0] = 1'b1;
      a[0]  = 8'h60;
      drive();
      model_step(1'b0);
      @(negedge clk);
      req[0] = 1'b0;
      drive();
      model_step(1'b0);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c == 1500 || c == 1501) begin
            reset = 1'b1;
            drive();
            model_step(1'b1);
         end else begin
            reset = 1'b0;
            random_inputs();
            drive();
            model_step(1'b0);
         end
      end
      @(negedge clk);
      #4;
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
